// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave in front of a NUM_REGS x 8 register file, oversampled on clk.
// Define SPI_SLAVE_AUTOINC_EN to step the address after every completed data byte.
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter  int NUM_REGS    = 32,
  parameter  int SYNC_STAGES = 2,
  localparam int AW          = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  input  logic          spi_ss_n,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  input  logic [7:0]    status_in,
  input  logic          loc_we,
  input  logic [AW-1:0] loc_addr,
  input  logic [7:0]    loc_wdata,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, CMD, RD, WR} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sclk_prev_q, ss_prev_q;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shift_in_q, shift_in_d;
  logic [7:0]             shift_out_q, shift_out_d;
  logic                   miso_q, miso_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic                   wr_valid_q, wr_valid_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic [7:0]             regs_q [NUM_REGS];

  logic          sclk_s, mosi_s, ss_s;
  logic          sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [7:0]    byte_in;
  logic [AW-1:0] addr_step;
  logic          spi_we;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ss_rise   = ss_s & ~ss_prev_q;
  assign ss_fall   = ~ss_s & ss_prev_q;
  assign byte_in   = {shift_in_q, mosi_s};

`ifdef SPI_SLAVE_AUTOINC_EN
  assign addr_step = (addr_q == AW'(NUM_REGS - 1)) ? '0 : addr_q + 1'b1;
`else
  assign addr_step = addr_q;
`endif

  // Synchronizers start low so a select held during reset never looks like a fresh falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    miso_d      = miso_q;
    addr_d      = addr_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    spi_we      = 1'b0;
    case (state_q)
      WAIT_IDLE: if (ss_s) state_d = IDLE;
      IDLE: begin
        if (ss_fall) begin
          state_d     = CMD;
          bit_cnt_d   = '0;
          miso_d      = status_in[7];
          shift_out_d = {status_in[6:0], 1'b0};
        end
      end
      CMD, RD, WR: begin
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          miso_d    = 1'b0;
        end else if (sclk_rise) begin
          shift_in_d = byte_in[6:0];
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              addr_d = AW'(byte_in[7:3]);
              if (byte_in[1]) begin
                state_d = WR;
              end else begin
                state_d     = RD;
                shift_out_d = regs_q[AW'(byte_in[7:3])];
              end
            end else if (state_q == WR) begin
              spi_we     = 1'b1;
              wr_valid_d = 1'b1;
              wr_addr_d  = addr_q;
              wr_data_d  = byte_in;
              addr_d     = addr_step;
            end else begin
              addr_d      = addr_step;
              shift_out_d = regs_q[addr_step];
            end
          end
        end else if (sclk_fall) begin
          // Byte loads land in shift_out_q unshifted, so the next falling edge presents their MSB.
          miso_d      = shift_out_q[7];
          shift_out_d = {shift_out_q[6:0], 1'b0};
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      miso_q      <= 1'b0;
      addr_q      <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      miso_q      <= miso_d;
      addr_q      <= addr_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // An SPI write to the same address as a local write in the same cycle takes precedence.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      if (loc_we && !(spi_we && (loc_addr == addr_q))) regs_q[loc_addr] <= loc_wdata;
      if (spi_we) regs_q[addr_q] <= byte_in;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ((state_q == CMD) || (state_q == RD) || (state_q == WR)) && !ss_s;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: a transaction-level model predicts MISO bytes,
// write events and register contents; a per-cycle monitor checks wr_valid events and quiet periods.
`timescale 1ns/1ps
module tb_spi_slave_responder;
  localparam int HALF = 8;

  logic       clk, reset;
  logic       spi_sclk, spi_mosi, spi_ss_n;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] status_in;
  logic       loc_we;
  logic [4:0] loc_addr;
  logic [7:0] loc_wdata;
  logic       wr_valid;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;

  spi_slave_responder #(.NUM_REGS(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .status_in(status_in),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic [7:0]  model [32];
  logic [12:0] exp_wr_q [$];
  bit          exp_sel;
  bit          exp_quiet;
  logic [7:0]  last_rx;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  // Every wr_valid cycle must match the next predicted write; quiet phases must keep OE low.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_valid) begin
        if (exp_wr_q.size() == 0) chk("wr_valid_extra", 32'(1), 32'(0));
        else chk("wr_event", {19'b0, wr_addr, wr_data}, {19'b0, exp_wr_q.pop_front()});
      end
      if (exp_quiet) chk("oe_quiet", 32'(spi_miso_oe), 32'(0));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode-0 master: drive MOSI while SCLK low, sample MISO at the rising edge.
  task automatic spi_bits(input logic [7:0] tx, input int nb, input bit coll, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < nb; i++) begin
      spi_mosi = tx[7-i];
      tick(HALF);
      spi_sclk = 1'b1;
      rx[7-i] = spi_miso;
      if (exp_sel) chk("oe_selected", 32'(spi_miso_oe), 32'(1));
      if (coll && i == nb - 1) begin
        tick(2);
        loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
        tick(HALF - 3);
      end else begin
        tick(HALF);
      end
      spi_sclk = 1'b0;
    end
  endtask

  task automatic ss_end();
    tick(HALF);
    spi_ss_n = 1'b1;
    tick(HALF);
    chk("oe_after_ss", 32'(spi_miso_oe), 32'(0));
    chk("miso_after_ss", 32'(spi_miso), 32'(0));
  endtask

  task automatic txn(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                     input logic [7:0] d1, input bit coll);
    logic [7:0] rx, tx, exp_rx;
    logic [4:0] a;
    bit         wr;
    spi_ss_n = 1'b0;
    tick(HALF);
    spi_bits(cmd, 8, 1'b0, rx);
    chk("cmd_status", 32'(rx), 32'(status_in));
    a  = cmd[7:3];
    wr = cmd[1];
    for (int k = 0; k < n; k++) begin
      tx     = (k == 0) ? d0 : d1;
      exp_rx = model[a];
      if (wr) begin
        exp_wr_q.push_back({a, tx});
        if (coll && k == 0 && loc_addr != a) model[loc_addr] = loc_wdata;
        model[a] = tx;
      end
      spi_bits(tx, 8, coll && (k == 0), rx);
      if (!wr) chk("rd_data", 32'(rx), 32'(exp_rx));
`ifdef SPI_SLAVE_AUTOINC_EN
      a = a + 5'd1;
`endif
    end
    last_rx = rx;
    ss_end();
  endtask

  initial begin
    logic [7:0] rx;
    for (int i = 0; i < 32; i++) model[i] = '0;
    reset = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_ss_n = 1'b0;
    status_in = 8'hA5; loc_we = 1'b0; loc_addr = '0; loc_wdata = '0;
    exp_sel = 1'b0; exp_quiet = 1'b1; last_rx = '0;
    tick(3);

    // Reset held mid-transaction, then released while the master keeps clocking.
    spi_bits(8'h0A, 3, 1'b0, rx);
    reset = 1'b0;
    chk("rst_miso", 32'(spi_miso), 32'(0));
    chk("rst_oe", 32'(spi_miso_oe), 32'(0));
    chk("rst_wr_valid", 32'(wr_valid), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    spi_bits(8'h55, 8, 1'b0, rx);
    spi_bits(8'h77, 8, 1'b0, rx);
    tick(HALF);
    spi_ss_n = 1'b1;
    tick(HALF);
    // SCLK toggling while deselected must be ignored.
    spi_bits(8'h0A, 8, 1'b0, rx);
    spi_bits(8'hFF, 8, 1'b0, rx);
    tick(HALF);
    exp_quiet = 1'b0;
    exp_sel   = 1'b1;

    // Write 0x3C to reg 2, then read it back.
    txn(8'h12, 1, 8'h3C, 8'h00, 1'b0);
    txn(8'h10, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg2", 32'(last_rx), 32'h3C);
    txn(8'h08, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg1_untouched", 32'(last_rx), 32'h00);

    // Aborted write to reg 7 after five data bits, then a normal read.
    status_in = 8'h5A;
    spi_ss_n = 1'b0;
    tick(HALF);
    spi_bits(8'h3A, 8, 1'b0, rx);
    chk("cmd_status_partial", 32'(rx), 32'h5A);
    spi_bits(8'hFF, 5, 1'b0, rx);
    ss_end();
    txn(8'h38, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg7_after_abort", 32'(last_rx), 32'h00);
    status_in = 8'hA5;

    // Local/SPI write collisions.
    loc_addr = 5'd4; loc_wdata = 8'h11;
    txn(8'h22, 1, 8'h99, 8'h00, 1'b1);
    txn(8'h20, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg4_spi_wins", 32'(last_rx), 32'h99);
    loc_addr = 5'd5;
    txn(8'h22, 1, 8'h99, 8'h00, 1'b1);
    txn(8'h28, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg5_local", 32'(last_rx), 32'h11);
    txn(8'h20, 1, 8'h00, 8'h00, 1'b0);
    chk("lit_reg4_kept", 32'(last_rx), 32'h99);

    // Two-byte burst starting at reg 31, then burst and single reads.
    txn(8'hFA, 2, 8'h01, 8'h02, 1'b0);
    txn(8'hF8, 2, 8'h00, 8'h00, 1'b0);
    txn(8'hF8, 1, 8'h00, 8'h00, 1'b0);
`ifdef SPI_SLAVE_AUTOINC_EN
    chk("lit_reg31_burst", 32'(last_rx), 32'h01);
`else
    chk("lit_reg31_burst", 32'(last_rx), 32'h02);
`endif
    txn(8'h00, 1, 8'h00, 8'h00, 1'b0);
`ifdef SPI_SLAVE_AUTOINC_EN
    chk("lit_reg0_burst", 32'(last_rx), 32'h02);
`else
    chk("lit_reg0_burst", 32'(last_rx), 32'h00);
`endif

    tick(4);
    chk("wr_events_all_seen", 32'(exp_wr_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
